// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int DATA_BITS_DFLT = 8;
  localparam int PRESC_W_DFLT   = 8;

  // Oversample index at which a bit is judged: just past the bit centre.
  function automatic int unsigned chk_point(input int unsigned p);
    return (p >> 1) + 2;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data-bit counter for the RX frame sequencer.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DFLT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               edge_clr,
  input  logic               edge_en,
  input  logic [PRESC_W-1:0] edge_last,
  input  logic               bit_clr,
  input  logic               bit_inc,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               edge_end
);

  assign edge_end = (edge_cnt == edge_last);

  // Edge counter: runs while a frame is active, wraps at the last oversample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
    end else if (edge_clr) begin
      edge_cnt <= '0;
    end else if (edge_en) begin
      edge_cnt <= edge_end ? '0 : edge_cnt + PRESC_W'(1);
    end
  end

  // Bit counter: advances once per data bit, cleared outside the data phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (bit_inc) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks IDLE/START/DATA/PARITY/STOP, strobes
// the datapath checkers and qualifies their flags into a one-cycle result.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DFLT,
  parameter int PRESC_W   = PRESC_W_DFLT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               Strt_Glitch,
  input  logic               Par_Err,
  input  logic               Stp_Err,
  output logic [PRESC_W-1:0] Edge_Cnt,
  output logic [3:0]         Bit_Cnt,
  output logic               Dat_Samp_En,
  output logic               Strt_Chk_En,
  output logic               Deser_En,
  output logic               Par_Chk_En,
  output logic               Stp_Chk_En,
  output logic               Data_Valid,
  output logic               Frame_Err
);

  rx_state_e          state, state_nxt;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q;
  logic               frame_go;
  logic               dv_nxt, fe_nxt;
  logic               dv_q, fe_q;
  logic               edge_end;
  logic               last_bit;
  logic [PRESC_W-1:0] edge_last;
  logic [PRESC_W-1:0] chk_pt;

  assign edge_last = presc_q - PRESC_W'(1);
  assign chk_pt    = PRESC_W'(chk_point(32'(presc_q)));
  assign last_bit  = (Bit_Cnt == 4'(DATA_BITS - 1));

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .edge_clr  (state == IDLE),
    .edge_en   (state != IDLE),
    .edge_last (edge_last),
    .bit_clr   ((state != DATA) || (edge_end && last_bit)),
    .bit_inc   ((state == DATA) && edge_end && !last_bit),
    .edge_cnt  (Edge_Cnt),
    .bit_cnt   (Bit_Cnt),
    .edge_end  (edge_end)
  );

  // Frame configuration is captured at each start so mid-frame CSR writes are ignored.
  always_ff @(posedge CLK) begin
    if (frame_go) begin
      presc_q  <= Prescale;
      par_en_q <= PAR_EN;
    end
  end

  // State register and registered result pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      dv_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      dv_q  <= dv_nxt;
      fe_q  <= fe_nxt;
    end
  end

  // Next-state decode and result qualification at each bit end.
  always_comb begin
    state_nxt = state;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    frame_go  = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_nxt = START;
          frame_go  = 1'b1;
        end
      end
      START: begin
        if (edge_end) begin
          state_nxt = Strt_Glitch ? IDLE : DATA;
          fe_nxt    = Strt_Glitch;
        end
      end
      DATA: begin
        if (edge_end && last_bit) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (edge_end) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (edge_end) begin
          dv_nxt = !(par_en_q && Par_Err) && !Stp_Err;
          fe_nxt = !dv_nxt;
          if (!RX_IN) begin
            state_nxt = START;
            frame_go  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Dat_Samp_En = (state != IDLE);
  assign Strt_Chk_En = (state == START);
  assign Deser_En    = (state == DATA) && (Edge_Cnt == chk_pt);
  assign Par_Chk_En  = (state == PARITY);
  assign Stp_Chk_En  = (state == STOP);
  assign Data_Valid  = dv_q;
  assign Frame_Err   = fe_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, models the checker flags,
// and scores result pulses against expected cycle and kind.
module tb_uart_rx_ctrl;

  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = 8'd8;
  logic          par_en = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;

  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic          data_valid, frame_err;

  uart_rx_ctrl #(.DATA_BITS(8), .PRESC_W(PW)) dut (
    .CLK         (clk),
    .RST         (rst),
    .RX_IN       (rx_in),
    .Prescale    (prescale),
    .PAR_EN      (par_en),
    .Strt_Glitch (strt_glitch),
    .Par_Err     (par_err),
    .Stp_Err     (stp_err),
    .Edge_Cnt    (edge_cnt),
    .Bit_Cnt     (bit_cnt),
    .Dat_Samp_En (dat_samp_en),
    .Strt_Chk_En (strt_chk_en),
    .Deser_En    (deser_en),
    .Par_Chk_En  (par_chk_en),
    .Stp_Chk_En  (stp_chk_en),
    .Data_Valid  (data_valid),
    .Frame_Err   (frame_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint cyc;
    int     kind;  // 1 = Data_Valid, 2 = Frame_Err
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_c = 6;
  int   deser_cnt = 0, par_cnt = 0, strt_cnt = 0, stp_cnt = 0;

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: strobe counters and scoreboard pop on result pulses.
  always @(negedge clk) begin
    if (deser_en) begin
      deser_cnt++;
      chk("deser_edge", edge_cnt, exp_c);
    end
    if (par_chk_en) par_cnt++;
    if (strt_chk_en) strt_cnt++;
    if (stp_chk_en) stp_cnt++;
    if (data_valid || frame_err) begin
      chk("dv_fe_excl", data_valid & frame_err, 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", data_valid | frame_err, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cyc", cyc, e.cyc);
        chk("pulse_kind", {frame_err, data_valid}, e.kind);
      end
    end
  end

  // Drive one full frame; caller is positioned just after a rising edge.
  task automatic send_frame(input logic [7:0] d, input bit pe, input int p, input bit tog);
    logic [10:0] bits;
    int          n;
    longint      c0;
    bit          ok;
    n    = pe ? 11 : 10;
    bits = pe ? {1'b1, ^d, d, 1'b0} : {1'b0, 1'b1, d, 1'b0};
    ok   = !(pe && par_err) && !stp_err;
    c0   = cyc;
    exp_c    = p / 2 + 2;
    prescale = PW'(p);
    par_en   = pe;
    sb.push_back('{cyc: c0 + 1 + longint'(n * p), kind: (ok ? 1 : 2)});
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      for (int k = 0; k < p; k++) begin
        tick();
        if (i == 0 && k == 0) begin
          prescale = 8'd12;
          par_en   = ~pe;
        end
        if (tog) par_err = ~par_err;
      end
    end
    rx_in = 1'b1;
    if (tog) par_err = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_edge"}, edge_cnt, 0);
    chk({tag, "_bit"}, bit_cnt, 0);
    chk({tag, "_samp"}, dat_samp_en, 0);
    chk({tag, "_strobes"}, {strt_chk_en, deser_en, par_chk_en, stp_chk_en}, 0);
    chk({tag, "_result"}, {data_valid, frame_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, s0, t0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (3) tick();

    // A: P=8, parity on, 0xA5, clean
    d0 = deser_cnt; p0 = par_cnt; s0 = stp_cnt; t0 = strt_cnt;
    send_frame(8'hA5, 1'b1, 8, 1'b0);
    drain(40);
    chk("a_deser", deser_cnt - d0, 8);
    chk("a_par", par_cnt - p0, 8);
    chk("a_stp", stp_cnt - s0, 8);
    chk("a_strt", strt_cnt - t0, 8);
    chk("a_idle", dat_samp_en, 0);
    repeat (4) tick();

    // B: same frame, stop error
    stp_err = 1'b1;
    send_frame(8'hA5, 1'b1, 8, 1'b0);
    drain(40);
    chk("b_idle", dat_samp_en, 0);
    stp_err = 1'b0;
    repeat (4) tick();

    // C: P=16, parity off, Par_Err toggling
    d0 = deser_cnt; p0 = par_cnt; s0 = stp_cnt;
    send_frame(8'h3C, 1'b0, 16, 1'b1);
    drain(40);
    chk("c_deser", deser_cnt - d0, 8);
    chk("c_par", par_cnt - p0, 0);
    chk("c_stp", stp_cnt - s0, 16);
    repeat (4) tick();

    // D: short glitch on the start bit
    d0 = deser_cnt; t0 = strt_cnt;
    prescale = 8'd8; par_en = 1'b0; strt_glitch = 1'b1; exp_c = 6;
    sb.push_back('{cyc: cyc + 1 + 8, kind: 2});
    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    drain(40);
    chk("d_idle", dat_samp_en, 0);
    chk("d_deser", deser_cnt - d0, 0);
    chk("d_strt", strt_cnt - t0, 8);
    strt_glitch = 1'b0;
    repeat (4) tick();

    // E: back-to-back frames, no idle between them
    d0 = deser_cnt;
    send_frame(8'h5A, 1'b0, 8, 1'b0);
    send_frame(8'hC3, 1'b0, 8, 1'b0);
    drain(40);
    chk("e_deser", deser_cnt - d0, 16);
    repeat (4) tick();

    // F: reset in the middle of the data phase, then a clean frame
    prescale = 8'd8; par_en = 1'b1; exp_c = 6;
    rx_in = 1'b0;
    repeat (8) tick();
    rx_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bit_cnt == 4'd4) break;
    end
    chk("f_bit4", bit_cnt, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("f_rst");
    repeat (100) tick();
    chk("f_sb_empty", sb.size(), 0);
    send_frame(8'h81, 1'b1, 8, 1'b0);
    drain(40);
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
